// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings for the load/store unit.
//   - access size encodings (byte / half / word / illegal)
//   - FSM state constants (IDLE, RD, CAP, WR, DONE, ERR)
//   - alignment check helper used when a request is accepted
package lsu_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_BAD  = 2'b11;

  typedef logic [2:0] lsu_state_t;

  localparam lsu_state_t ST_IDLE = 3'd0;
  localparam lsu_state_t ST_RD   = 3'd1;
  localparam lsu_state_t ST_CAP  = 3'd2;
  localparam lsu_state_t ST_WR   = 3'd3;
  localparam lsu_state_t ST_DONE = 3'd4;
  localparam lsu_state_t ST_ERR  = 3'd5;

  // True when a request can never be serviced: conflicting read+write,
  // illegal size, or an offset that does not fit the access width.
  function automatic logic req_illegal(input logic       rd,
                                       input logic       wr,
                                       input logic [1:0] size,
                                       input logic [1:0] offset);
    logic bad;
    bad = rd & wr;
    case (size)
      SIZE_HALF: bad = bad | offset[0];
      SIZE_WORD: bad = bad | (offset != 2'b00);
      SIZE_BAD:  bad = 1'b1;
      default:   bad = bad;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational little-endian lane steering.
//   word_i          whole word read from memory (captured copy)
//   store_data_i    right-justified store value
//   offset_i        byte offset within the word (address[1:0])
//   size_i          access size encoding
//   load_unsigned_i 1 = zero-extend sub-word loads, 0 = sign-extend
//   load_data_o     addressed lane extracted and extended to 32 bits
//   merge_data_o    word_i with the addressed lane(s) replaced by store data
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] store_data_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        load_unsigned_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merge_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel    = word_i[{offset_i, 3'b000} +: 8];
    half_sel    = offset_i[1] ? word_i[31:16] : word_i[15:0];
    load_data_o = '0;
    case (size_i)
      SIZE_BYTE: load_data_o = {{24{~load_unsigned_i & byte_sel[7]}}, byte_sel};
      SIZE_HALF: load_data_o = {{16{~load_unsigned_i & half_sel[15]}}, half_sel};
      SIZE_WORD: load_data_o = word_i;
      default:   load_data_o = '0;
    endcase
  end

  // Each byte lane independently decides whether it keeps the old memory
  // byte or takes a byte of the store value.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_d;
      always_comb begin
        lane_d = word_i[8*gi +: 8];
        case (size_i)
          SIZE_BYTE: if (offset_i == 2'(gi))     lane_d = store_data_i[7:0];
          SIZE_HALF: if (offset_i[1] == 1'(gi/2)) lane_d = store_data_i[8*(gi%2) +: 8];
          SIZE_WORD: lane_d = store_data_i[8*gi +: 8];
          default:   lane_d = word_i[8*gi +: 8];
        endcase
      end
      assign merge_data_o[8*gi +: 8] = lane_d;
    end
  endgenerate

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage front end of data_Memory.
// Converts byte/half/word requests into whole-word memory accesses; sub-word
// stores use read-modify-write, loads are sign/zero-extended.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   memRead, memWrite          load / store request (held while stall=1)
//   address, storeData         byte address, right-justified store value
//   size, loadUnsigned         00 byte, 01 half, 10 word, 11 illegal; zero-extend
//   memAddress                 word index to data_Memory (wraps)
//   memWriteData               full word to data_Memory
//   memReadData                word from data_Memory (one cycle after strobe)
//   memRegRead, memRegWrite    one-cycle strobes to data_Memory
//   loadData                   extended load result, valid while done=1
//   done, misaligned           completion pulse, error pulse
//   stall                      freezes IF..EX/MEM while an access is busy
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [31:0]       address,
  input  logic [31:0]       storeData,
  input  logic [1:0]        size,
  input  logic              loadUnsigned,
  output logic [ADDR_W-1:0] memAddress,
  output logic [31:0]       memWriteData,
  input  logic [31:0]       memReadData,
  output logic              memRegRead,
  output logic              memRegWrite,
  output logic [31:0]       loadData,
  output logic              done,
  output logic              misaligned,
  output logic              stall
);

  lsu_state_t        state_q, state_d;
  logic [ADDR_W+1:0] addr_q;
  logic [1:0]        size_q;
  logic [31:0]       data_q;
  logic              uns_q;
  logic              store_q;
  logic [31:0]       buf_q;

  logic              req;
  logic              illegal;
  logic [31:0]       ext_data;
  logic [31:0]       merge_data;

  assign req     = memRead | memWrite;
  assign illegal = req_illegal(memRead, memWrite, size, address[1:0]);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (illegal)                           state_d = ST_ERR;
          else if (memWrite && size == SIZE_WORD) state_d = ST_WR;
          else                                   state_d = ST_RD;
        end
      end
      ST_RD:   state_d = ST_CAP;
      ST_CAP:  state_d = store_q ? ST_WR : ST_DONE;
      ST_WR:   state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      data_q  <= '0;
      uns_q   <= 1'b0;
      store_q <= 1'b0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && req) begin
        addr_q  <= address[ADDR_W+1:0];
        size_q  <= size;
        data_q  <= storeData;
        uns_q   <= loadUnsigned;
        store_q <= memWrite;
      end
      if (state_q == ST_CAP) begin
        buf_q <= memReadData;
      end
    end
  end

  lsu_lane_align u_align (
    .word_i          (buf_q),
    .store_data_i    (data_q),
    .offset_i        (addr_q[1:0]),
    .size_i          (size_q),
    .load_unsigned_i (uns_q),
    .load_data_o     (ext_data),
    .merge_data_o    (merge_data)
  );

  // Every output decodes from registered state, so the memory index stays
  // fixed from RD through WR and nothing but reset can cut an access short.
  assign memAddress   = addr_q[ADDR_W+1:2];
  assign memRegRead   = (state_q == ST_RD);
  assign memRegWrite  = (state_q == ST_WR);
  assign memWriteData = memRegWrite ? merge_data : '0;
  assign done         = (state_q == ST_DONE) || (state_q == ST_ERR);
  assign misaligned   = (state_q == ST_ERR);
  assign loadData     = (state_q == ST_DONE && !store_q) ? ext_data : '0;
  // The idle term looks straight at the request inputs; it is masked by reset
  // so every output is low while reset is held.
  assign stall        = !reset && ((state_q == ST_IDLE && req) ||
                                   state_q == ST_RD || state_q == ST_CAP ||
                                   state_q == ST_WR);

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int ADDR_W = 9;

  logic              clk = 1'b0;
  logic              reset;
  logic              memRead, memWrite;
  logic [31:0]       address, storeData;
  logic [1:0]        size;
  logic              loadUnsigned;
  logic [ADDR_W-1:0] memAddress;
  logic [31:0]       memWriteData, memReadData;
  logic              memRegRead, memRegWrite;
  logic [31:0]       loadData;
  logic              done, misaligned, stall;

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .memRead      (memRead),
    .memWrite     (memWrite),
    .address      (address),
    .storeData    (storeData),
    .size         (size),
    .loadUnsigned (loadUnsigned),
    .memAddress   (memAddress),
    .memWriteData (memWriteData),
    .memReadData  (memReadData),
    .memRegRead   (memRegRead),
    .memRegWrite  (memRegWrite),
    .loadData     (loadData),
    .done         (done),
    .misaligned   (misaligned),
    .stall        (stall)
  );

  always #5 clk = ~clk;

  // Synchronous data memory: read data appears the cycle after the strobe.
  logic [31:0] mem [0:(1<<ADDR_W)-1];
  logic [31:0] rd_q;
  always @(posedge clk) begin
    if (memRegWrite) mem[memAddress] <= memWriteData;
    if (memRegRead)  rd_q <= mem[memAddress];
  end
  assign memReadData = rd_q;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  logic [ADDR_W-1:0] last_wr_addr = '0;

  typedef struct {
    logic [31:0] load;
    logic        mis;
    int          cyc;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Strobe counter, also records where the last write went.
  initial forever begin
    @(negedge clk);
    if (memRegRead)  rd_cnt++;
    if (memRegWrite) begin
      wr_cnt++;
      last_wr_addr = memAddress;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT signals completion.
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      if (memRegRead && memRegWrite) chk("strobe_overlap", 32'd1, 32'd0);
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("loadData",   loadData, mon_e.load);
          chk("misaligned", {31'd0, misaligned}, {31'd0, mon_e.mis});
          chk("done_cycle", 32'(cyc), 32'(mon_e.cyc));
        end
      end else if (misaligned) begin
        chk("misaligned_without_done", 32'd1, 32'd0);
      end
    end
  end

  // Drive one request at a negedge, push its expectation, hold inputs until done.
  task automatic do_req(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [1:0] sz, input logic uns,
                        input logic [31:0] exp_ld, input logic exp_mis, input int lat,
                        input int exp_rd, input int exp_wr);
    exp_t e;
    int   rd0, wr0;
    bit   got;
    memRead = rd; memWrite = wr; address = a; storeData = d;
    size = sz; loadUnsigned = uns;
    // Issued during a DONE cycle, the unit first returns to IDLE.
    e.load = exp_ld; e.mis = exp_mis; e.cyc = cyc + lat + (done ? 1 : 0);
    sb.push_back(e);
    rd0 = rd_cnt; wr0 = wr_cnt; got = 0;
    $display("REQ rd=%0b wr=%0b addr=%h data=%h size=%0d uns=%0b", rd, wr, a, d, sz, uns);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        break;
      end
      chk("stall_busy", {31'd0, stall}, 32'd1);
    end
    if (!got) begin
      chk("done_timeout", 32'd0, 32'd1);
      if (sb.size() > 0) void'(sb.pop_back());
    end
    chk("stall_in_done", {31'd0, stall}, 32'd0);
    chk("rd_strobes", 32'(rd_cnt - rd0), 32'(exp_rd));
    chk("wr_strobes", 32'(wr_cnt - wr0), 32'(exp_wr));
  endtask

  task automatic idle();
    memRead = 0; memWrite = 0; address = '0; storeData = '0;
    size = '0; loadUnsigned = 0;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_stall"},        {31'd0, stall},       32'd0);
    chk({tag, "_done"},         {31'd0, done},        32'd0);
    chk({tag, "_misaligned"},   {31'd0, misaligned},  32'd0);
    chk({tag, "_memRegRead"},   {31'd0, memRegRead},  32'd0);
    chk({tag, "_memRegWrite"},  {31'd0, memRegWrite}, 32'd0);
    chk({tag, "_memWriteData"}, memWriteData,         32'd0);
    chk({tag, "_memAddress"},   32'(memAddress),      32'd0);
    chk({tag, "_loadData"},     loadData,             32'd0);
  endtask

  initial begin
    int wr0;
    reset = 1;
    idle();
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    reset = 0;
    @(negedge clk);
    chk_outputs_zero("idle");

    // mem[1] = 80FF_1234 through a word store
    do_req(0, 1, 32'h4, 32'h80FF_1234, SIZE_WORD, 0, 32'h0, 0, 2, 0, 1); idle();
    chk("mem1_init", mem[1], 32'h80FF_1234);
    // byte loads of lane 3 (0x80)
    do_req(1, 0, 32'h7, 32'h0, SIZE_BYTE, 0, 32'hFFFF_FF80, 0, 3, 1, 0); idle();
    do_req(1, 0, 32'h7, 32'h0, SIZE_BYTE, 1, 32'h0000_0080, 0, 3, 1, 0); idle();
    // half store into the upper half via RMW; upper store bits must be ignored
    do_req(0, 1, 32'h4, 32'h1111_2222, SIZE_WORD, 0, 32'h0, 0, 2, 0, 1); idle();
    do_req(0, 1, 32'h6, 32'hCAFE_BEEF, SIZE_HALF, 0, 32'h0, 0, 4, 1, 1); idle();
    chk("mem1_half_store", mem[1], 32'hBEEF_2222);
    // word store to 0x800 wraps to word index 0
    do_req(0, 1, 32'h800, 32'hDEAD_BEEF, SIZE_WORD, 0, 32'h0, 0, 2, 0, 1); idle();
    chk("wrap_wr_addr", 32'(last_wr_addr), 32'd0);
    chk("mem0_wrap", mem[0], 32'hDEAD_BEEF);
    // misaligned half load: error pulse, no strobes
    do_req(1, 0, 32'h3, 32'h0, SIZE_HALF, 0, 32'h0, 1, 1, 0, 0); idle();
    // byte store into lane 1
    do_req(0, 1, 32'h5, 32'h0000_00A5, SIZE_BYTE, 0, 32'h0, 0, 4, 1, 1); idle();
    chk("mem1_byte_store", mem[1], 32'hBEEF_A522);
    do_req(1, 0, 32'h4, 32'h0, SIZE_HALF, 0, 32'hFFFF_A522, 0, 3, 1, 0); idle();
    do_req(1, 0, 32'h6, 32'h0, SIZE_HALF, 1, 32'h0000_BEEF, 0, 3, 1, 0); idle();
    // other illegal requests
    do_req(1, 0, 32'h0, 32'h0, SIZE_BAD,  0, 32'h0, 1, 1, 0, 0); idle();
    do_req(1, 1, 32'h0, 32'h0, SIZE_WORD, 0, 32'h0, 1, 1, 0, 0); idle();
    do_req(1, 0, 32'h2, 32'h0, SIZE_WORD, 0, 32'h0, 1, 1, 0, 0); idle();
    // back-to-back load then store, second issued in the DONE cycle
    do_req(1, 0, 32'h0, 32'h0, SIZE_WORD, 0, 32'hDEAD_BEEF, 0, 3, 1, 0);
    do_req(0, 1, 32'hC, 32'h1357_9BDF, SIZE_WORD, 0, 32'h0, 0, 2, 0, 1); idle();
    chk("mem3_b2b", mem[3], 32'h1357_9BDF);

    // reset during CAP of a byte store
    do_req(0, 1, 32'h8, 32'h0102_0304, SIZE_WORD, 0, 32'h0, 0, 2, 0, 1); idle();
    @(negedge clk);
    memWrite = 1; address = 32'h8; storeData = 32'hFF; size = SIZE_BYTE;
    wr0 = wr_cnt;
    $display("REQ byte store addr=00000008 aborted by reset in CAP");
    @(negedge clk);  // RD
    @(negedge clk);  // CAP
    chk("cap_stall", {31'd0, stall}, 32'd1);
    reset = 1;
    idle();
    #1;
    chk_outputs_zero("abort");
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("abort_mem2", mem[2], 32'h0102_0304);
    chk("abort_wr_strobes", 32'(wr_cnt - wr0), 32'd0);
    chk_outputs_zero("after_abort");
    do_req(1, 0, 32'h8, 32'h0, SIZE_WORD, 0, 32'h0102_0304, 0, 3, 1, 0); idle();

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
